// File: rtl/afg_pkg.sv
// ----------------------------------------------------------------------------
// afg_pkg
// Shared definitions for the function-generator square-wave path.
//   DW_DEF  : default sample/level data width
//   LW_DEF  : default segment length counter width
//   ST_*    : state encoding of the square-wave sequencer
// ----------------------------------------------------------------------------
package afg_pkg;

    localparam int DW_DEF = 12;
    localparam int LW_DEF = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_LOW  = 2'd2;

endpackage : afg_pkg

// File: rtl/sq_seg_counter.sv
// ----------------------------------------------------------------------------
// sq_seg_counter
// Counts accepted samples inside one high or low segment.
//   i_clk      : system clock, rising edge
//   i_rst_n    : asynchronous active-low reset
//   i_clear    : return the count to 0 (wins over i_advance)
//   i_advance  : step the count by one
//   i_len      : segment length in samples (0 behaves as 1)
//   o_cnt      : current index inside the segment
//   o_last     : o_cnt is the last index of the segment
// ----------------------------------------------------------------------------
module sq_seg_counter
    import afg_pkg::*;
#(
    parameter int LW = LW_DEF
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clear,
    input  logic          i_advance,
    input  logic [LW-1:0] i_len,
    output logic [LW-1:0] o_cnt,
    output logic          o_last
);

    logic [LW-1:0] r_cnt;
    logic [LW-1:0] w_last_idx;

    // A zero length is folded to a single-sample segment.
    assign w_last_idx = (i_len == '0) ? '0 : (i_len - LW'(1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_advance) begin
            r_cnt <= r_cnt + LW'(1);
        end
    end

    assign o_cnt  = r_cnt;
    assign o_last = (r_cnt == w_last_idx);

endmodule : sq_seg_counter

// File: rtl/sq_wave_gen.sv
// ----------------------------------------------------------------------------
// sq_wave_gen
// Turns the latched square-wave level/length registers into a stream of DAC
// sample codes. Settings are captured into shadow registers only at the start
// of a period, so register writes never disturb a period already running.
//
// Handshake: a sample is transferred on every rising clock edge where
// o_dvalid and i_dready are both 1. While o_dvalid=1 and i_dready=0, o_dout,
// the state and the segment count hold. o_dvalid never drops without a
// transfer except through reset or the stop at a period end.
//
//   i_clk, i_rst_n      : clock (rising edge), asynchronous active-low reset
//   i_enable            : run request, sampled in IDLE and at period end
//   i_high_level/_low_  : DAC codes for the high/low segment
//   i_high_len/_low_    : samples per high/low segment (0 behaves as 1)
//   o_dout, o_dvalid    : registered sample code and its valid flag
//   i_dready            : DAC side accepts the current sample
//   o_phase             : 1 while emitting the high segment
//   o_period_done       : one-cycle pulse after the last low sample is taken
//   o_state, o_seg_cnt  : debug view of the sequencer state and counter
// ----------------------------------------------------------------------------
module sq_wave_gen
    import afg_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int LW = LW_DEF
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_enable,
    input  logic [DW-1:0] i_high_level,
    input  logic [DW-1:0] i_low_level,
    input  logic [LW-1:0] i_high_len,
    input  logic [LW-1:0] i_low_len,
    output logic [DW-1:0] o_dout,
    output logic          o_dvalid,
    input  logic          i_dready,
    output logic          o_phase,
    output logic          o_period_done,
    output logic [1:0]    o_state,
    output logic [LW-1:0] o_seg_cnt
);

    logic [1:0]    r_state;
    logic [1:0]    w_next_state;
    logic [DW-1:0] r_dout;
    logic [DW-1:0] w_next_dout;
    logic          r_period_done;

    logic [DW-1:0] r_sh_high_level;
    logic [DW-1:0] r_sh_low_level;
    logic [LW-1:0] r_sh_high_len;
    logic [LW-1:0] r_sh_low_len;

    logic          w_dvalid;
    logic          w_acc;
    logic          w_last;
    logic          w_seg_end;
    logic          w_period_end;
    logic          w_load;
    logic [LW-1:0] w_seg_len;
    logic [LW-1:0] w_cnt;

    assign w_dvalid     = (r_state == ST_HIGH) || (r_state == ST_LOW);
    assign w_acc        = w_dvalid & i_dready;
    assign w_seg_end    = w_acc & w_last;
    assign w_period_end = w_seg_end & (r_state == ST_LOW);

    // Shadows reload when a period starts: from IDLE, or back-to-back at the
    // end of the previous period.
    assign w_load = ((r_state == ST_IDLE) & i_enable) | (w_period_end & i_enable);

    assign w_seg_len = (r_state == ST_LOW) ? r_sh_low_len : r_sh_high_len;

    sq_seg_counter #(
        .LW (LW)
    ) u_seg_counter (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (w_load | w_seg_end),
        .i_advance (w_acc & ~w_last),
        .i_len     (w_seg_len),
        .o_cnt     (w_cnt),
        .o_last    (w_last)
    );

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (i_enable) w_next_state = ST_HIGH;
            ST_HIGH: if (w_seg_end) w_next_state = ST_LOW;
            ST_LOW:  if (w_seg_end) w_next_state = i_enable ? ST_HIGH : ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        o_dvalid      = w_dvalid;
        o_phase       = (r_state == ST_HIGH);
        o_dout        = r_dout;
        o_period_done = r_period_done;
        o_state       = r_state;
        o_seg_cnt     = w_cnt;
    end

    // Next sample code. A new period takes the high level straight from the
    // input since the shadow is being written on the same edge.
    always_comb begin
        w_next_dout = r_dout;
        if (w_load) begin
            w_next_dout = i_high_level;
        end else if (w_acc && (r_state == ST_HIGH)) begin
            w_next_dout = w_last ? r_sh_low_level : r_sh_high_level;
        end else if (w_acc && (r_state == ST_LOW) && !w_last) begin
            w_next_dout = r_sh_low_level;
        end
    end

    // Data path registers: sample code, period pulse and shadow settings.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dout          <= '0;
            r_period_done   <= 1'b0;
            r_sh_high_level <= '0;
            r_sh_low_level  <= '0;
            r_sh_high_len   <= '0;
            r_sh_low_len    <= '0;
        end else begin
            r_dout        <= w_next_dout;
            r_period_done <= w_period_end;
            if (w_load) begin
                r_sh_high_level <= i_high_level;
                r_sh_low_level  <= i_low_level;
                r_sh_high_len   <= i_high_len;
                r_sh_low_len    <= i_low_len;
            end
        end
    end

endmodule : sq_wave_gen

// File: tb/tb_sq_wave_gen.sv
module tb_sq_wave_gen;
  import afg_pkg::*;

  localparam int DW = 12;
  localparam int LW = 16;

  // ---------------------------------------------------------------- clock/reset
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          dready = 1'b0;
  logic [DW-1:0] hl = '0;
  logic [DW-1:0] ll = '0;
  logic [LW-1:0] hlen = '0;
  logic [LW-1:0] llen = '0;

  logic [DW-1:0] dout;
  logic          dvalid;
  logic          phase;
  logic          pd;
  logic [1:0]    state;
  logic [LW-1:0] seg_cnt;

  always #5 clk = ~clk;

  sq_wave_gen #(.DW(DW), .LW(LW)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_enable      (enable),
    .i_high_level  (hl),
    .i_low_level   (ll),
    .i_high_len    (hlen),
    .i_low_len     (llen),
    .o_dout        (dout),
    .o_dvalid      (dvalid),
    .i_dready      (dready),
    .o_phase       (phase),
    .o_period_done (pd),
    .o_state       (state),
    .o_seg_cnt     (seg_cnt)
  );

  // ---------------------------------------------------------------- scoreboard
  int n_checks = 0;
  int n_fail = 0;

  // Entry: [13]=last sample of period, [12]=phase, [11:0]=code.
  // exp_q[0] is the sample the DUT must be presenting this cycle.
  logic [13:0]   exp_q[$];
  logic [DW-1:0] exp_hold = '0;
  logic          exp_pd = 1'b0;
  logic [DW-1:0] acc_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // A whole period from the current input settings.
  task automatic push_period();
    int h;
    int l;
    h = (hlen == '0) ? 1 : int'(hlen);
    l = (llen == '0) ? 1 : int'(llen);
    for (int i = 0; i < h; i++) exp_q.push_back({1'b0, 1'b1, hl});
    for (int i = 0; i < l; i++) exp_q.push_back({(i == l - 1), 1'b0, ll});
  endtask

  // Compare, then advance the model to what the next rising edge produces.
  always @(negedge clk) begin
    logic [13:0] e;
    logic        acc;
    if (!rst_n) begin
      exp_q.delete();
      exp_hold = '0;
      exp_pd = 1'b0;
      chk("rst_dout", 32'(dout), 32'(0));
      chk("rst_dvalid", 32'(dvalid), 32'(0));
      chk("rst_phase", 32'(phase), 32'(0));
      chk("rst_pd", 32'(pd), 32'(0));
    end else begin
      chk("dvalid", 32'(dvalid), 32'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
        chk("dout", 32'(dout), 32'(exp_q[0][11:0]));
        chk("phase", 32'(phase), 32'(exp_q[0][12]));
      end else begin
        chk("dout_idle", 32'(dout), 32'(exp_hold));
        chk("phase_idle", 32'(phase), 32'(0));
      end
      chk("period_done", 32'(pd), 32'(exp_pd));
      acc = (exp_q.size() > 0) && dready;
      exp_pd = 1'b0;
      if (acc) begin
        e = exp_q.pop_front();
        exp_hold = e[11:0];
        acc_log.push_back(e[11:0]);
        if (e[13]) begin
          exp_pd = 1'b1;
          if (enable) push_period();
        end
      end else if ((exp_q.size() == 0) && enable) begin
        push_period();
      end
    end
  end

  // ---------------------------------------------------------------- driver tasks
  task automatic drive_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic set_cfg(input logic [DW-1:0] h, input logic [DW-1:0] l,
                         input logic [LW-1:0] hn, input logic [LW-1:0] ln);
    hl = h;
    ll = l;
    hlen = hn;
    llen = ln;
  endtask

  // Wait (after an edge) until the current sample has the given phase.
  task automatic wait_phase(input logic want, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      drive_edge();
      if ((exp_q.size() > 0) && (exp_q[0][12] == want)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout_fail(name);
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      drive_edge();
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout_fail(name);
  endtask

  task automatic chk_log(input string name, input int idx, input logic [DW-1:0] exp);
    if (idx < acc_log.size()) chk(name, 32'(acc_log[idx]), 32'(exp));
    else chk(name, 32'hDEAD_BEEF, 32'(exp));
  endtask

  // ---------------------------------------------------------------- stimulus
  logic [3:0] bp_pat;

  initial begin
    // Reset state
    repeat (3) drive_edge();
    chk("reset_state", 32'(state), 32'(ST_IDLE));
    chk("reset_cnt", 32'(seg_cnt), 32'(0));
    rst_n = 1'b1;
    drive_edge();

    // Basic waveform and enable latency
    set_cfg(12'hFFF, 12'h000, 16'd3, 16'd2);
    dready = 1'b1;
    enable = 1'b1;
    acc_log.delete();
    @(negedge clk);
    #1 chk("latency_c0", 32'(dvalid), 32'(0));
    @(negedge clk);
    #1 chk("latency_c1", 32'(dvalid), 32'(1));
    repeat (12) drive_edge();
    chk_log("basic0", 0, 12'hFFF);
    chk_log("basic2", 2, 12'hFFF);
    chk_log("basic3", 3, 12'h000);
    chk_log("basic4", 4, 12'h000);
    chk_log("basic5", 5, 12'hFFF);
    chk_log("basic9", 9, 12'h000);

    // Backpressure 1,0,0,1
    bp_pat = 4'b1001;
    for (int i = 0; i < 40; i++) begin
      dready = bp_pat[i % 4];
      drive_edge();
    end
    dready = 1'b1;

    // Shadowing: change settings during the first LOW sample
    wait_phase(1'b1, "wait_high_sh");
    wait_phase(1'b0, "wait_low_sh");
    set_cfg(12'h800, 12'h000, 16'd1, 16'd2);
    acc_log.delete();
    repeat (8) drive_edge();
    chk_log("shadow0", 0, 12'h000);
    chk_log("shadow1", 1, 12'h000);
    chk_log("shadow2", 2, 12'h800);
    chk_log("shadow3", 3, 12'h000);
    chk_log("shadow5", 5, 12'h800);

    // Graceful stop at the 2nd high sample
    enable = 1'b0;
    wait_idle("wait_idle_stop");
    set_cfg(12'hFFF, 12'h000, 16'd3, 16'd2);
    enable = 1'b1;
    wait_phase(1'b1, "wait_high_stop");
    drive_edge();
    enable = 1'b0;
    acc_log.delete();
    repeat (8) drive_edge();
    chk("stop_count", 32'(acc_log.size()), 32'(4));
    chk_log("stop0", 0, 12'hFFF);
    chk_log("stop1", 1, 12'hFFF);
    chk_log("stop2", 2, 12'h000);
    chk_log("stop3", 3, 12'h000);
    chk("stop_dvalid", 32'(dvalid), 32'(0));
    chk("stop_state", 32'(state), 32'(ST_IDLE));
    chk("stop_dout_hold", 32'(dout), 32'(12'h000));

    // Zero length / inverted levels
    set_cfg(12'h100, 12'h200, 16'd0, 16'd0);
    acc_log.delete();
    enable = 1'b1;
    repeat (10) drive_edge();
    chk_log("zero0", 0, 12'h100);
    chk_log("zero1", 1, 12'h200);
    chk_log("zero2", 2, 12'h100);
    chk_log("zero3", 3, 12'h200);

    // Randomized run
    for (int i = 0; i < 600; i++) begin
      dready = ($urandom_range(0, 3) != 0);
      enable = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 19) == 0) begin
        set_cfg(DW'($urandom_range(0, 4095)), DW'($urandom_range(0, 4095)),
                LW'($urandom_range(0, 4)), LW'($urandom_range(0, 4)));
      end
      drive_edge();
    end

    // Asynchronous reset mid-HIGH
    set_cfg(12'hABC, 12'h123, 16'd3, 16'd2);
    dready = 1'b1;
    enable = 1'b1;
    wait_phase(1'b1, "wait_high_rst");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_dout", 32'(dout), 32'(0));
    chk("arst_dvalid", 32'(dvalid), 32'(0));
    chk("arst_phase", 32'(phase), 32'(0));
    repeat (2) drive_edge();
    rst_n = 1'b1;
    acc_log.delete();
    repeat (8) drive_edge();
    chk_log("restart0", 0, 12'hABC);
    chk_log("restart2", 2, 12'hABC);
    chk_log("restart3", 3, 12'h123);

    enable = 1'b0;
    repeat (10) drive_edge();

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_sq_wave_gen

// File: doc/sq_wave_gen.md
Name: sq_wave_gen

Overview:
- Reader/consumer side of the square-wave voltage level registers in the function generator.
- Takes the latched 12-bit high/low levels and segment lengths, and produces a stream of 12-bit DAC sample codes.
- Output uses a valid/ready handshake toward the DAC interface.
- Settings are shadowed at period boundaries, so register writes never glitch a period in progress.

Parameters:
- DW, 12, sample/level data width
- LW, 16, segment length counter width (samples per high or low segment)

Ports:
- Clock  input  1  system clock, rising edge
- Reset  input  1  asynchronous, active-low reset
- Enable  input  1  run request; sampled in IDLE and at each period end
- HighLevel  input  DW  DAC code for the high segment (from level register output)
- LowLevel  input  DW  DAC code for the low segment
- HighLen  input  LW  number of samples in the high segment
- LowLen  input  LW  number of samples in the low segment
- Dout  output  DW  current sample code (registered)
- Dvalid  output  1  Dout holds a valid sample
- Dready  input  1  DAC interface accepts a sample when Dvalid and Dready are both 1
- Phase  output  1  1 while in HIGH, 0 otherwise
- PeriodDone  output  1  one-cycle pulse on acceptance of the last LOW sample

Behaviour:
- Reset (asynchronous, Reset=0) sets:
  - state=IDLE
  - Dout=0, Dvalid=0, Phase=0, PeriodDone=0
  - segment counter=0
  - all shadow registers=0
- States: IDLE, HIGH, LOW.
- Accept event: acc = Dvalid & Dready.
- IDLE:
  - Dvalid=0.
  - If Enable=1 at a clock edge: load shadows (HighLevel, LowLevel, HighLen, LowLen), go to HIGH, cnt=0, Dout=HighLevel, Dvalid=1, Phase=1.
  - Latency Enable→Dvalid is 1 cycle.
- Length rule: a shadow length of 0 is treated as 1. The effective last index is max(len,1)-1.
- HIGH:
  - On acc with cnt≠lastH: cnt+1.
  - On acc with cnt=lastH: go to LOW, cnt=0, Dout=shadow LowLevel, Phase=0.
- LOW:
  - On acc with cnt≠lastL: cnt+1.
  - On acc with cnt=lastL: PeriodDone=1 for the next cycle only, then:
    - Enable=1: reload shadows from inputs, go to HIGH, cnt=0, Dout=new HighLevel, Phase=1, Dvalid stays 1. There is no bubble between periods.
    - Enable=0: go to IDLE, Dvalid=0, Dout holds the last low code.
- Backpressure: while Dvalid=1 and Dready=0, Dout, state and cnt hold unchanged.
- Enable deasserted mid-period: the current period completes in full, then the block stops at the period end. A partial period is never emitted.
- Input changes mid-period: ignored until the next shadow load.
- Reset mid-operation: immediate return to the reset values. Dvalid drops asynchronously.
- No arithmetic on levels. LowLevel > HighLevel is legal and emitted as-is (inverted wave).
- cnt width is LW; it never exceeds the last index, so there is no wrap.

Decomposition:
- Shared package (afg_pkg) holds:
  - DW and LW defaults
  - state encoding constants ST_IDLE=2'd0, ST_HIGH=2'd1, ST_LOW=2'd2
- One sub-module, sq_seg_counter: LW-bit counter with clear, advance-on-accept and a terminal-count flag (cnt == max(len,1)-1).
- The FSM, shadow registers and output register stay in sq_wave_gen.

Test Plan:
- Basic waveform:
  - Stimulus: HighLevel=0xFFF, LowLevel=0x000, HighLen=3, LowLen=2, Enable=1, Dready=1.
  - Response: Dvalid rises 1 cycle after Enable; Dout sequence is FFF,FFF,FFF,000,000 repeating; PeriodDone pulses once per 5 accepts.
- Backpressure:
  - Stimulus: same settings, Dready toggles 1,0,0,1,...
  - Response: Dout and Phase are frozen while Dready=0; exactly 3 high and 2 low samples are accepted per period.
- Shadowing:
  - Stimulus: change HighLevel to 0x800 and HighLen to 1 during the first LOW segment.
  - Response: the remainder of the current period is unchanged; the next period is 800,000,000.
- Graceful stop:
  - Stimulus: drop Enable at the 2nd high sample.
  - Response: the full period (3 high, 2 low) completes; Dvalid=0 the cycle after the last low accept; the state returns to IDLE.
- Zero length / inversion:
  - Stimulus: HighLen=0, LowLen=0, HighLevel=0x100, LowLevel=0x200.
  - Response: Dout alternates 100,200 every accept.
- Asynchronous reset:
  - Stimulus: assert Reset=0 between clock edges mid-HIGH.
  - Response: Dout=0, Dvalid=0 and Phase=0 immediately, without waiting for a clock edge; after release with Enable=1, restarts from HIGH with cnt=0.
